// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost/full/empty flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     w_in,
  input  logic                     r_in,
  input  logic                     err_clr,
  output logic [WIDTH-1:0]         data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL   = (AW+1)'(AE_LEVEL);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic rd_acc, wr_acc;
  assign fill_count   = wr_ptr - rd_ptr;
  assign fifo_full    = fill_count == FULL_LVL;
  assign fifo_empty   = fill_count == '0;
  assign almost_full  = fill_count >= AF_LVL;
  assign almost_empty = fill_count <= AE_LVL;
  assign rd_acc       = r_in && !fifo_empty;
  // a read at full frees the slot the simultaneous write lands in
  assign wr_acc       = w_in && (!fifo_full || rd_acc);
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= data_in;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
      overflow  <= (w_in && !wr_acc) || (overflow && !err_clr);
      underflow <= (r_in && !rd_acc) || (underflow && !err_clr);
    end
`ifdef FIFO_FWFT_EN
  assign data_out = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) data_out <= '0;
    else if (rd_acc) data_out <= mem[rd_ptr[AW-1:0]];
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed scoreboard bench for sync_fifo_flags (WIDTH=4, DEPTH=8, AF=6, AE=2).
module tb_sync_fifo_flags;
  logic       clk = 0, rst = 0;
  logic [3:0] data_in = '0;
  logic       w_in = 0, r_in = 0, err_clr = 0;
  logic [3:0] data_out;
  logic       fifo_full, fifo_empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] fill_count;
  logic       exp_rd = 0;
  logic [3:0] exp_q [$];
  int total = 0, bad = 0;
  int occ, wi, ri;

  sync_fifo_flags #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .w_in(w_in), .r_in(r_in), .err_clr(err_clr),
    .data_out(data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fill_count(fill_count),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // pops one expected word for each read the stimulus declared as accepted
  task automatic pop_chk();
    if (exp_q.size() == 0) chk("rd_queue_empty", 1, 0);
    else chk("rd_data", int'(data_out), int'(exp_q.pop_front()));
  endtask

`ifdef FIFO_FWFT_EN
  always @(negedge clk) if (exp_rd) pop_chk();
`else
  always @(posedge clk) begin
    logic pend;
    pend = exp_rd;
    #1;
    if (pend) pop_chk();
  end
`endif

  // inputs are applied 2 time units after a rising edge; returns 2 units after the applying edge
  task automatic step(input logic w, input logic [3:0] d, input logic r, input logic clr,
                      input logic ev, input logic [3:0] ed);
    w_in = w; data_in = d; r_in = r; err_clr = clr; exp_rd = ev;
    if (ev) exp_q.push_back(ed);
    @(posedge clk); #2;
    w_in = 0; r_in = 0; err_clr = 0; exp_rd = 0;
  endtask

  task automatic chk_status(input string tag, input int cnt);
    chk({tag, "_fill"}, int'(fill_count), cnt);
    chk({tag, "_empty"}, int'(fifo_empty), int'(cnt == 0));
    chk({tag, "_full"}, int'(fifo_full), int'(cnt == 8));
    chk({tag, "_afull"}, int'(almost_full), int'(cnt >= 6));
    chk({tag, "_aempty"}, int'(almost_empty), int'(cnt <= 2));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk_status("reset0", 0);
    chk("reset0_dout", int'(data_out), 0);
    rst = 1;
    @(posedge clk); #2;
    // put data in flight, then reset asynchronously mid-cycle
    step(1, 4'd1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 4'd1);
    step(1, 4'd2, 0, 0, 0, 0);
    step(1, 4'd4, 0, 0, 0, 0);
    chk_status("pre_rst", 2);
    rst = 0;
    #1;
    chk_status("async_rst", 0);
    chk("async_rst_dout", int'(data_out), 0);
    chk("async_rst_ovf", int'(overflow), 0);
    chk("async_rst_unf", int'(underflow), 0);
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #2;
    step(1, 4'd5, 0, 0, 0, 0);
    chk_status("after_rst_wr", 1);
    step(0, 0, 1, 0, 1, 4'd5);
    chk_status("after_rst_rd", 0);
    // fill 0..7 then overflow with 9
    for (int i = 0; i < 8; i++) begin
      step(1, 4'(i), 0, 0, 0, 0);
      chk_status($sformatf("fill%0d", i), i + 1);
    end
    step(1, 4'd9, 0, 0, 0, 0);
    chk("ovf_set", int'(overflow), 1);
    chk_status("ovf", 8);
    step(0, 0, 0, 1, 0, 0);
    chk("ovf_clr", int'(overflow), 0);
    // simultaneous read+write at full
    step(1, 4'd3, 1, 0, 1, 4'd0);
    chk_status("simul", 8);
    chk("simul_ovf", int'(overflow), 0);
    for (int i = 1; i < 8; i++) step(0, 0, 1, 0, 1, 4'(i));
    step(0, 0, 1, 0, 1, 4'd3);
    chk_status("drained", 0);
    // underflow and clear
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("unf_set", int'(underflow), 1);
    chk_status("unf", 0);
`ifdef FIFO_FWFT_EN
    chk("unf_dout", int'(data_out), 0);
`else
    chk("unf_dout", int'(data_out), 3);
`endif
    step(0, 0, 0, 1, 0, 0);
    chk("unf_clr", int'(underflow), 0);
    step(0, 0, 1, 1, 0, 0);
    chk("unf_set_wins", int'(underflow), 1);
    step(0, 0, 0, 1, 0, 0);
    chk("unf_clr2", int'(underflow), 0);
    // wrap-around: bursts of 4 writes then 4 reads, 20 words total
    occ = 0; wi = 0; ri = 0;
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        step(1, 4'(wi % 16), 0, 0, 0, 0);
        wi++; occ++;
        chk("wrap_fill", int'(fill_count), occ);
        chk("wrap_aempty", int'(almost_empty), int'(occ <= 2));
      end
      for (int k = 0; k < 4; k++) begin
        step(0, 0, 1, 0, 1, 4'(ri % 16));
        ri++; occ--;
        chk("wrap_fill", int'(fill_count), occ);
        chk("wrap_aempty", int'(almost_empty), int'(occ <= 2));
      end
    end
    chk("wrap_ovf", int'(overflow), 0);
    chk("wrap_unf", int'(underflow), 0);
    // single word on an empty FIFO
    step(1, 4'd7, 0, 0, 0, 0);
`ifdef FIFO_FWFT_EN
    chk("fwft_present", int'(data_out), 7);
`else
    chk("reg_hold", int'(data_out), 3);
`endif
    step(0, 0, 1, 0, 1, 4'd7);
    chk_status("last", 0);
`ifdef FIFO_FWFT_EN
    chk("fwft_empty_dout", int'(data_out), 0);
`else
    chk("reg_last_dout", int'(data_out), 7);
`endif
    @(posedge clk); #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
